main_memory_responder: RTL and testbench

- Memory-side end of the cache-to-main-memory block interface. Services block refills (read) and dirty-block write-backs (write) issued by the cache controller on a miss.
- Holds 1 KiB of byte-addressed storage: 64 blocks of 4 words each.
- Fixed, parameterised access latency and a req/ready handshake.
- Sits directly below the cache and replaces the combinational main memory model so that miss timing is realistic.

---
 rtl/main_memory_responder.sv | 144 ++++++++++++++
 tb/tb_main_memory_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// Memory-side responder for cache block refills and write-backs: 2^ADDR_WIDTH bytes
// organised as 16-byte blocks, fixed access latency, one-cycle ready pulse.
module main_memory_responder #(
    parameter int ACCESS_LATENCY = 4,
    parameter int ADDR_WIDTH     = 10,
    parameter int BLOCK_WORDS    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_from_cache,
    input  logic                      read_write_from_cache,
    input  logic [ADDR_WIDTH-1:0]     address_from_cache,
    input  logic [32*BLOCK_WORDS-1:0] write_block_from_cache,
    output logic [32*BLOCK_WORDS-1:0] read_block_out,
    output logic                      ready_out,
    output logic                      busy_out
);

    localparam int BLOCK_BYTES = 4 * BLOCK_WORDS;
    localparam int BLOCK_BITS  = 8 * BLOCK_BYTES;
    localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
    localparam int INDEX_W     = ADDR_WIDTH - OFFSET_W;
    localparam int NUM_BLOCKS  = 1 << INDEX_W;
    localparam logic [7:0] LAT_INIT = 8'(ACCESS_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic                   accept_s, complete_s;
    logic [7:0]             counter_r;
    logic [INDEX_W-1:0]     index_r;
    logic                   rw_r;
    logic [BLOCK_BITS-1:0]  wdata_r;
    logic [BLOCK_BITS-1:0]  rdata_r;
    logic                   ready_r, busy_r;
    logic [BLOCK_BITS-1:0]  mem_r [NUM_BLOCKS];
    logic                   unused_offset_s;

    // Byte i of the memory powers up holding i[7:0], little-endian within each word.
    function automatic logic [BLOCK_BITS-1:0] reset_block(input int idx);
        logic [BLOCK_BITS-1:0] blk;
        blk = {BLOCK_BITS{1'b0}};
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            blk[b*8 +: 8] = 8'(idx * BLOCK_BYTES + b);
        end
        return blk;
    endfunction

    // Offset bits never select a sub-block.
    assign unused_offset_s = ^address_from_cache[OFFSET_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; requests are only taken in IDLE, never during DONE.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_from_cache) begin
                    state_s  = ST_BUSY;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (counter_r == 8'd0) begin
                    state_s    = ST_DONE;
                    complete_s = 1'b1;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Request latch, latency counter and registered handshake/read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_r <= 8'd0;
            index_r   <= {INDEX_W{1'b0}};
            rw_r      <= 1'b0;
            wdata_r   <= {BLOCK_BITS{1'b0}};
            rdata_r   <= {BLOCK_BITS{1'b0}};
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else if (accept_s) begin
            index_r   <= address_from_cache[ADDR_WIDTH-1:OFFSET_W];
            rw_r      <= read_write_from_cache;
            wdata_r   <= write_block_from_cache;
            counter_r <= LAT_INIT;
            busy_r    <= 1'b1;
            ready_r   <= 1'b0;
        end else if (state_r == ST_BUSY) begin
            if (counter_r != 8'd0) begin
                counter_r <= counter_r - 8'd1;
            end else begin
                busy_r  <= 1'b0;
                ready_r <= 1'b1;
                // Write completions leave the last read data in place.
                if (!rw_r) begin
                    rdata_r <= mem_r[index_r];
                end else begin
                    rdata_r <= rdata_r;
                end
            end
        end else begin
            ready_r <= 1'b0;
        end
    end

    // Storage: re-initialised on reset, so an aborted write is never committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                mem_r[i] <= reset_block(i);
            end
        end else if (complete_s && rw_r) begin
            mem_r[index_r] <= wdata_r;
        end else begin
            mem_r[index_r] <= mem_r[index_r];
        end
    end

    assign read_block_out = rdata_r;
    assign ready_out      = ready_r;
    assign busy_out       = busy_r;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: directed vector table, corner-case sequences and
// random traffic checked against a byte-array memory model.
module tb_main_memory_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req, rw, sel;
    logic [9:0]   addr;
    logic [127:0] wdata;
    logic         req0, req1, rdy0, rdy1, bsy0, bsy1;
    logic [127:0] rd0, rd1;
    logic         mon_rdy, mon_bsy;
    logic [127:0] mon_rd;

    always #5 clk = ~clk;

    assign req0    = req & ~sel;
    assign req1    = req & sel;
    assign mon_rdy = sel ? rdy1 : rdy0;
    assign mon_bsy = sel ? bsy1 : bsy0;
    assign mon_rd  = sel ? rd1 : rd0;

    main_memory_responder #(.ACCESS_LATENCY(4), .ADDR_WIDTH(10), .BLOCK_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_from_cache(req0), .read_write_from_cache(rw),
        .address_from_cache(addr), .write_block_from_cache(wdata),
        .read_block_out(rd0), .ready_out(rdy0), .busy_out(bsy0)
    );

    main_memory_responder #(.ACCESS_LATENCY(1), .ADDR_WIDTH(10), .BLOCK_WORDS(4)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .req_from_cache(req1), .read_write_from_cache(rw),
        .address_from_cache(addr), .write_block_from_cache(wdata),
        .read_block_out(rd1), .ready_out(rdy1), .busy_out(bsy1)
    );

    localparam logic [127:0] PAT_000 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] PAT_3F0 = 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0;
    localparam logic [127:0] PAT_040 = 128'h4F4E4D4C_4B4A4948_47464544_43424140;
    localparam logic [127:0] ONES    = {4{32'hFFFFFFFF}};
    localparam logic [127:0] MIXED   = 128'h01234567_89ABCDEF_DEADBEEF_CAFEF00D;

    typedef struct {
        bit           rw;
        logic [9:0]   addr;
        logic [127:0] wdata;
        logic [127:0] exp_rd;
        string        name;
    } vec_t;

    vec_t         vecs[8];
    int           tests = 0;
    int           fails = 0;
    byte unsigned ref_mem[1024];
    logic [127:0] last_rd0;

    function automatic void model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i);
        last_rd0 = 128'd0;
    endfunction

    function automatic logic [127:0] model_block(input logic [9:0] a);
        logic [127:0] blk;
        int base;
        base = int'(a) & ~15;
        for (int k = 0; k < 16; k++) blk[k*8 +: 8] = ref_mem[base + k];
        return blk;
    endfunction

    function automatic void model_write(input logic [9:0] a, input logic [127:0] d);
        int base;
        base = int'(a) & ~15;
        for (int k = 0; k < 16; k++) ref_mem[base + k] = d[k*8 +: 8];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at the negedge just after acceptance; n = edges since acceptance when ready seen.
    task automatic wait_ready(output int n, output bit busy_bad);
        n = 0;
        busy_bad = 1'b0;
        while (!mon_rdy && n < 300) begin
            if (!mon_bsy) busy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic transact(input bit s, input bit r_w, input logic [9:0] a,
                            input logic [127:0] d, input logic [127:0] exp_rd,
                            input int lat, input string name);
        int n;
        bit busy_bad;
        sel = s; req = 1'b1; rw = r_w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        wait_ready(n, busy_bad);
        req = 1'b0;
        check({name, "_latency"}, 128'(n), 128'(lat));
        check({name, "_busy"}, {126'd0, busy_bad, mon_bsy}, 128'd0);
        check({name, "_data"}, mon_rd, exp_rd);
        @(negedge clk);
        check({name, "_pulse"}, {126'd0, mon_rdy, mon_bsy}, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit busy_bad;
        logic [127:0] exp;
        logic [9:0] ra;
        bit rrw;

        vecs[0] = '{1'b0, 10'h000, 128'd0, PAT_000, "rd_000"};
        vecs[1] = '{1'b1, 10'h200, ONES,   PAT_000, "wr_200"};
        vecs[2] = '{1'b0, 10'h200, 128'd0, ONES,    "rd_200"};
        vecs[3] = '{1'b0, 10'h000, 128'd0, PAT_000, "rd_000_again"};
        vecs[4] = '{1'b0, 10'h00F, 128'd0, PAT_000, "rd_00f_alias"};
        vecs[5] = '{1'b0, 10'h3F0, 128'd0, PAT_3F0, "rd_3f0"};
        vecs[6] = '{1'b1, 10'h2AB, MIXED,  PAT_3F0, "wr_2ab_alias"};
        vecs[7] = '{1'b0, 10'h2A4, 128'd0, MIXED,   "rd_2a4"};

        rst_n = 1'b0; req = 1'b0; rw = 1'b0; sel = 1'b0; addr = 10'd0; wdata = 128'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {125'd0, rdy0, bsy0, rdy1}, 128'd0);
        check("reset_rdata", rd0, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            transact(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 4, vecs[i].name);
            if (vecs[i].rw) model_write(vecs[i].addr, vecs[i].wdata);
            else last_rd0 = vecs[i].exp_rd;
        end

        // req held high throughout; address and data wiggle while busy
        sel = 1'b0; req = 1'b1; rw = 1'b0; addr = 10'h100; wdata = 128'd0;
        @(posedge clk);
        @(negedge clk);
        addr = 10'h300; wdata = ONES;
        wait_ready(n, busy_bad);
        check("hold_latency", 128'(n), 128'd4);
        check("hold_busy", {127'd0, busy_bad}, 128'd0);
        check("hold_data_100", rd0, model_block(10'h100));
        @(negedge clk);
        check("hold_done_gap", {126'd0, rdy0, bsy0}, 128'd0);
        @(negedge clk);
        check("hold_reaccept", {126'd0, rdy0, bsy0}, 128'd1);
        @(negedge clk);
        wait_ready(n, busy_bad);
        check("hold2_latency", 128'(n + 1), 128'd4);
        check("hold2_data_300", rd0, model_block(10'h300));
        req = 1'b0;
        last_rd0 = model_block(10'h300);
        @(negedge clk);
        check("hold2_pulse", {127'd0, rdy0}, 128'd0);

        for (int i = 0; i < 30; i++) begin
            rrw = 1'($urandom_range(0, 1));
            ra  = 10'($urandom_range(0, 1023));
            exp = rrw ? last_rd0 : model_block(ra);
            transact(1'b0, rrw, ra, {$urandom, $urandom, $urandom, $urandom}, exp, 4, "rand");
            if (rrw) model_write(ra, wdata);
            else last_rd0 = exp;
        end

        // reset two cycles into a write: nothing committed, outputs cleared at once
        sel = 1'b0; req = 1'b1; rw = 1'b1; addr = 10'h040; wdata = {4{32'hDEADBEEF}};
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", {127'd0, bsy0}, 128'd1);
        rst_n = 1'b0; req = 1'b0;
        #1;
        check("midreset_flags", {126'd0, rdy0, bsy0}, 128'd0);
        check("midreset_rdata", rd0, 128'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        transact(1'b0, 1'b0, 10'h040, 128'd0, PAT_040, 4, "rd_040_after_reset");

        transact(1'b1, 1'b0, 10'h3F0, 128'd0, PAT_3F0, 1, "l1_rd_3f0");
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
